pipe_stage_ctrl: RTL and testbench
==================================

# pipe_stage_ctrl

Parametrised inter-stage register bank and pipeline sequencer for the MIPS datapath. It replaces the hard-wired IF/ID, ID/EX, EX/MEM and MEM/WB registers with NB_STAGES uniform payload slots. Each slot carries a valid bit and supports stall, per-stage flush and bubble injection. A run/step/drain/halt sequencer gates every pipeline advance and the PC write enable, and keeps a cycle counter for debug readout.

## Interface
- NB_STAGES, 4, number of inter-stage registers; slot 0 = IF/ID, slot NB_STAGES-1 = MEM/WB; legal range 2..8.
- NB_DATA, 160, payload width per slot; narrower stage buses are zero-extended by the caller.
- NB_CNT, 32, cycle counter width.
- i_clk  input  1  single clock; all state updates on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_mode  input  1  0 = continuous run, 1 = single-step.
- i_step  input  1  step pulse; one advance per cycle it is high while in WAIT_STEP.
- i_stage_data  input  NB_STAGES*NB_DATA  producer outputs; slice k feeds slot k.
- i_stall_req  input  1  load-use stall request from hazard logic.
- i_flush_req  input  NB_STAGES  per-slot flush request (branch/jump squash).
- i_halt_detect  input  1  HALT opcode decoded from slot 0 contents.
- o_stage_data  output  NB_STAGES*NB_DATA  registered slot contents.
- o_stage_valid  output  NB_STAGES  per-slot valid.
- o_pc_en  output  1  PC write enable (combinational).
- o_state  output  2  0 RUN, 1 WAIT_STEP, 2 DRAIN, 3 HALTED.
- o_halted  output  1  high in HALTED.
- o_cycle_count  output  NB_CNT  advances since reset.

## Operation
- Reset values: all slot data 0, o_stage_valid 0, state RUN, o_cycle_count 0, o_halted 0. o_pc_en is forced 0 while i_rst is high.
- Internal adv (combinational):
  - RUN: 1.
  - WAIT_STEP: i_step.
  - DRAIN: 1.
  - HALTED: 0.
- When adv=0:
  - Every slot, valid bit, flush and stall request is ignored; all slots hold.
  - o_pc_en = 0.
- When adv=1, slot k next value is decided in priority order:
  - i_flush_req[k] → bubble.
  - else k==0 and i_stall_req → hold.
  - else k==1 and i_stall_req → bubble.
  - else k==0 and state is DRAIN or a halt is accepted this cycle → bubble.
  - else load slice k of i_stage_data with valid 1. Slots k≥2 load regardless of stall.
- A bubble is data all-zero (MIPS NOP) with valid 0.
- o_pc_en = adv & ~i_stall_req & (state != DRAIN) & ~halt_accept.
- Halt accept: halt_accept = adv & i_halt_detect & o_stage_valid[0] & ~i_stall_req & ~i_flush_req[1] & (state != DRAIN). The halt instruction enters slot 1 on this advance; the transition to DRAIN is defined in the state machine below.
- State transitions, evaluated each cycle, halt accept first:
  - halt_accept → DRAIN, drain counter loaded with NB_STAGES-1.
  - RUN → WAIT_STEP when i_mode=1.
  - WAIT_STEP → RUN when i_mode=0. A simultaneous i_step still yields its advance.
  - DRAIN: counter decrements per advance; at 1→0 go to HALTED. i_mode is ignored.
  - HALTED: absorbing; only i_rst exits.
- o_cycle_count increments on every advance and saturates at all ones.

## Timing
- Slot k output reflects slice k exactly one advancing rising edge after it was presented.
- Stall: slot 0 and PC hold for each stalled cycle. The bubble lands in slot 1 on the same edge.
- Flush takes effect on the edge it is sampled; a flushed slot shows valid 0 the next cycle.
- Step: one i_step cycle produces exactly one edge of movement. i_step held for N cycles produces N advances.
- Halt: o_halted rises NB_STAGES-1 advances after the accept edge. o_pc_en is 0 from the accept cycle onward.
- Async reset mid-DRAIN or mid-stall returns everything to reset values immediately, without waiting for a clock edge.

## Test plan
- NB_STAGES=4, NB_DATA=8. Run mode, i_stage_data={8'h44,8'h33,8'h22,8'h11} every cycle → after 1 edge o_stage_data matches, valid=4'b1111, count=1.
- Stall for 2 cycles with slice 0 changing 8'hA1→8'hA2 → slot 0 keeps its prior value, slot 1 = 0 with valid[1]=0, o_pc_en=0, slots 2–3 keep advancing, count +2.
- i_flush_req=4'b0011 together with i_stall_req → slots 0 and 1 bubble, valid=4'b1100, o_pc_en=0.
- i_mode=1 with no step for 5 cycles → all slots hold, count unchanged. Then a 1-cycle i_step → exactly one advance, count +1.
- Halt accepted at cycle t → o_pc_en=0 from cycle t, state=DRAIN, slot 0 bubbles. State reaches HALTED and o_halted=1 after 3 advances (edge t+3). Further stimulus changes nothing.
- Assert i_rst asynchronously mid-DRAIN → outputs at reset values before the next clock edge. After release, state=RUN.

Source files
------------

// File: rtl/pipe_stage_ctrl_if.sv
// Bundle of slot payloads, hazard requests and PC enable exchanged between
// the MIPS datapath (master) and the inter-stage register controller (slave).
interface pipe_stage_ctrl_if #(
  parameter int NB_STAGES = 4,
  parameter int NB_DATA   = 160
);
  logic [NB_STAGES*NB_DATA-1:0] i_stage_data;
  logic                         i_stall_req;
  logic [NB_STAGES-1:0]         i_flush_req;
  logic                         i_halt_detect;
  logic [NB_STAGES*NB_DATA-1:0] o_stage_data;
  logic [NB_STAGES-1:0]         o_stage_valid;
  logic                         o_pc_en;

  modport master (
    output i_stage_data, i_stall_req, i_flush_req, i_halt_detect,
    input  o_stage_data, o_stage_valid, o_pc_en
  );

  modport slave (
    input  i_stage_data, i_stall_req, i_flush_req, i_halt_detect,
    output o_stage_data, o_stage_valid, o_pc_en
  );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Uniform inter-stage register bank (IF/ID .. MEM/WB) with stall, flush and
// bubble handling, gated by a run/step/drain/halt sequencer and cycle counter.
module pipe_stage_ctrl #(
  parameter int NB_STAGES = 4,
  parameter int NB_DATA   = 160,
  parameter int NB_CNT    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_mode,
  input  logic                i_step,
  pipe_stage_ctrl_if.slave    bus,
  output logic [1:0]          o_state,
  output logic                o_halted,
  output logic [NB_CNT-1:0]   o_cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_STEP = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_HALTED    = 2'd3
  } state_t;

  localparam int DRAIN_W = (NB_STAGES > 2) ? $clog2(NB_STAGES) : 1;

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [NB_CNT-1:0]    cnt_q;
  logic                 adv;
  logic                 halt_accept;

  logic [NB_DATA-1:0]   slot_data_p0 [NB_STAGES];
  logic [NB_STAGES-1:0] vld_p0;
  logic [NB_DATA-1:0]   slot_data_d  [NB_STAGES];
  logic [NB_STAGES-1:0] vld_d;

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + NB_CNT'(1);
  endfunction

  // Advance gate and halt acceptance
  always_comb begin
    adv = 1'b0;
    unique case (state_q)
      ST_RUN:       adv = 1'b1;
      ST_WAIT_STEP: adv = i_step;
      ST_DRAIN:     adv = 1'b1;
      ST_HALTED:    adv = 1'b0;
      default:      adv = 1'b0;
    endcase
  end

  assign halt_accept = adv & bus.i_halt_detect & vld_p0[0] & ~bus.i_stall_req
                     & ~bus.i_flush_req[1] & (state_q != ST_DRAIN);

  // PC must stay frozen while reset is asserted even though the FSM reads RUN.
  assign bus.o_pc_en = ~i_rst & adv & ~bus.i_stall_req
                     & (state_q != ST_DRAIN) & ~halt_accept;

  // Slot next-value selection: flush > stall hold/bubble > drain bubble > load
  always_comb begin
    for (int k = 0; k < NB_STAGES; k++) begin
      slot_data_d[k] = slot_data_p0[k];
      vld_d[k]       = vld_p0[k];
      if (adv) begin
        if (bus.i_flush_req[k]) begin
          slot_data_d[k] = '0;
          vld_d[k]       = 1'b0;
        end else if (k == 0 && bus.i_stall_req) begin
          slot_data_d[k] = slot_data_p0[k];
          vld_d[k]       = vld_p0[k];
        end else if (k == 1 && bus.i_stall_req) begin
          slot_data_d[k] = '0;
          vld_d[k]       = 1'b0;
        end else if (k == 0 && (state_q == ST_DRAIN || halt_accept)) begin
          slot_data_d[k] = '0;
          vld_d[k]       = 1'b0;
        end else begin
          slot_data_d[k] = bus.i_stage_data[k*NB_DATA +: NB_DATA];
          vld_d[k]       = 1'b1;
        end
      end
    end
  end

  // Stage register bank
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NB_STAGES; k++) begin
        slot_data_p0[k] <= '0;
      end
      vld_p0 <= '0;
    end else begin
      slot_data_p0 <= slot_data_d;
      vld_p0       <= vld_d;
    end
  end

  for (genvar g = 0; g < NB_STAGES; g++) begin : g_out
    assign bus.o_stage_data[g*NB_DATA +: NB_DATA] = slot_data_p0[g];
  end
  assign bus.o_stage_valid = vld_p0;

  // Sequencer next state; an accepted halt overrides any mode change.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (halt_accept) begin
      state_d = ST_DRAIN;
      drain_d = DRAIN_W'(NB_STAGES - 1);
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (i_mode) state_d = ST_WAIT_STEP;
        end
        ST_WAIT_STEP: begin
          if (!i_mode) state_d = ST_RUN;
        end
        ST_DRAIN: begin
          if (adv) begin
            drain_d = drain_q - DRAIN_W'(1);
            if (drain_q == DRAIN_W'(1)) state_d = ST_HALTED;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (adv) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign o_state       = state_q;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl (4 slots x 8 bits, 8-bit counter): scenario tasks
// plus a reference model whose per-edge predictions go through a queue.
module tb_pipe_stage_ctrl;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       step;
  logic [1:0] state;
  logic       halted;
  logic [7:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  pipe_stage_ctrl_if #(.NB_STAGES(4), .NB_DATA(8)) bus ();

  pipe_stage_ctrl #(.NB_STAGES(4), .NB_DATA(8), .NB_CNT(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_mode        (mode),
    .i_step        (step),
    .bus           (bus),
    .o_state       (state),
    .o_halted      (halted),
    .o_cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  vld;
    logic [1:0]  st;
    logic        hlt;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_data;
  logic [3:0]  m_vld;
  logic [1:0]  m_st;
  logic [1:0]  m_drain;
  logic [7:0]  m_cnt;

  task automatic model_reset();
    m_data = '0; m_vld = '0; m_st = 2'd0; m_drain = 2'd0; m_cnt = 8'd0;
  endtask

  // Called at posedge+1; drives one cycle, checks pc_en, predicts and checks the edge.
  task automatic cycle(input logic [31:0] d, input logic stall, input logic [3:0] fl,
                       input logic hd, input logic md, input logic stp);
    logic adv, hacc, pc;
    exp_t e, g;
    bus.i_stage_data  = d;
    bus.i_stall_req   = stall;
    bus.i_flush_req   = fl;
    bus.i_halt_detect = hd;
    mode = md;
    step = stp;
    adv  = (m_st == 2'd0) || (m_st == 2'd2) || (m_st == 2'd1 && stp);
    hacc = adv && hd && m_vld[0] && !stall && !fl[1] && (m_st != 2'd2);
    pc   = adv && !stall && (m_st != 2'd2) && !hacc;
    #1;
    checks++;
    if (bus.o_pc_en !== pc) begin
      failures++;
      $display("FAIL sb_pc_en t=%0t got=%b exp=%b", $time, bus.o_pc_en, pc);
    end
    if (adv) begin
      for (int k = 0; k < 4; k++) begin
        if (fl[k]) begin
          m_data[k*8 +: 8] = 8'h00; m_vld[k] = 1'b0;
        end else if (k == 0 && stall) begin
          m_vld[k] = m_vld[k];
        end else if (k == 1 && stall) begin
          m_data[k*8 +: 8] = 8'h00; m_vld[k] = 1'b0;
        end else if (k == 0 && (m_st == 2'd2 || hacc)) begin
          m_data[k*8 +: 8] = 8'h00; m_vld[k] = 1'b0;
        end else begin
          m_data[k*8 +: 8] = d[k*8 +: 8]; m_vld[k] = 1'b1;
        end
      end
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    if (hacc) begin
      m_st = 2'd2; m_drain = 2'd3;
    end else begin
      case (m_st)
        2'd0: if (md) m_st = 2'd1;
        2'd1: if (!md) m_st = 2'd0;
        2'd2: begin
          m_drain = m_drain - 2'd1;
          if (m_drain == 2'd0) m_st = 2'd3;
        end
        default: m_st = m_st;
      endcase
    end
    e.data = m_data; e.vld = m_vld; e.st = m_st; e.hlt = (m_st == 2'd3); e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    checks++;
    if (bus.o_stage_data !== g.data) begin
      failures++;
      $display("FAIL sb_data t=%0t got=%h exp=%h", $time, bus.o_stage_data, g.data);
    end
    checks++;
    if (bus.o_stage_valid !== g.vld) begin
      failures++;
      $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, bus.o_stage_valid, g.vld);
    end
    checks++;
    if (state !== g.st) begin
      failures++;
      $display("FAIL sb_state t=%0t got=%0d exp=%0d", $time, state, g.st);
    end
    checks++;
    if (halted !== g.hlt) begin
      failures++;
      $display("FAIL sb_halted t=%0t got=%b exp=%b", $time, halted, g.hlt);
    end
    checks++;
    if (cycle_count !== g.cnt) begin
      failures++;
      $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, cycle_count, g.cnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.i_stage_data = 32'hDEADBEEF; bus.i_stall_req = 1'b0; bus.i_flush_req = 4'h0;
    bus.i_halt_detect = 1'b0; mode = 1'b0; step = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_stage_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.o_stage_data); end
    checks++;
    if (bus.o_stage_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%b exp=0000", bus.o_stage_valid); end
    checks++;
    if (state !== 2'd0 || halted !== 1'b0) begin failures++; $display("FAIL reset_state got=%0d/%b exp=0/0", state, halted); end
    checks++;
    if (cycle_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
    checks++;
    if (bus.o_pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en got=%b exp=0", bus.o_pc_en); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_run();
    cycle(32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.o_stage_data !== 32'h44332211 || bus.o_stage_valid !== 4'hF || cycle_count !== 8'd1) begin
      failures++;
      $display("FAIL run_load got=%h/%b/%0d exp=44332211/1111/1", bus.o_stage_data, bus.o_stage_valid, cycle_count);
    end
  endtask

  task automatic test_stall();
    cycle(32'h443322A1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(32'h665544A2, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.o_stage_data !== 32'h665500A1 || bus.o_stage_valid !== 4'b1101) begin
      failures++;
      $display("FAIL stall_1 got=%h/%b exp=665500a1/1101", bus.o_stage_data, bus.o_stage_valid);
    end
    cycle(32'h887766A2, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.o_stage_data !== 32'h887700A1 || cycle_count !== 8'd4) begin
      failures++;
      $display("FAIL stall_2 got=%h/%0d exp=887700a1/4", bus.o_stage_data, cycle_count);
    end
    cycle(32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    cycle(32'h44332211, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.o_stage_data !== 32'h44330000 || bus.o_stage_valid !== 4'b1100) begin
      failures++;
      $display("FAIL flush_stall got=%h/%b exp=44330000/1100", bus.o_stage_data, bus.o_stage_valid);
    end
    cycle(32'h0C0B0A09, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.o_stage_valid !== 4'hF || cycle_count !== 8'd7) begin
      failures++;
      $display("FAIL flush_refill got=%b/%0d exp=1111/7", bus.o_stage_valid, cycle_count);
    end
  endtask

  task automatic test_step();
    cycle(32'h14131211, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(32'h50505050 + i, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (bus.o_stage_data !== 32'h14131211 || cycle_count !== 8'd8 || state !== 2'd1) begin
      failures++;
      $display("FAIL step_wait got=%h/%0d/%0d exp=14131211/8/1", bus.o_stage_data, cycle_count, state);
    end
    cycle(32'h24232221, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.o_stage_data !== 32'h24232221 || cycle_count !== 8'd9) begin
      failures++;
      $display("FAIL step_one got=%h/%0d exp=24232221/9", bus.o_stage_data, cycle_count);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(32'h30303030 + i, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    end
    checks++;
    if (cycle_count !== 8'd12) begin failures++; $display("FAIL step_held got=%0d exp=12", cycle_count); end
    cycle(32'h34333231, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 2'd0 || cycle_count !== 8'd13) begin
      failures++;
      $display("FAIL step_exit got=%0d/%0d exp=0/13", state, cycle_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      cycle($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
            1'b0, ($urandom_range(0, 3) == 0), 1'($urandom));
    end
    for (int i = 0; i < 260; i++) begin
      cycle($urandom, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (cycle_count !== 8'hFF) begin failures++; $display("FAIL count_saturate got=%0d exp=255", cycle_count); end
  endtask

  task automatic test_halt();
    do_reset();
    cycle(32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(32'h44332211, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd2 || bus.o_stage_valid !== 4'b1110 || bus.o_pc_en !== 1'b0) begin
      failures++;
      $display("FAIL halt_accept got=%0d/%b/%b exp=2/1110/0", state, bus.o_stage_valid, bus.o_pc_en);
    end
    cycle(32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(32'h44332211, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'd2 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_draining got=%0d/%b exp=2/0", state, halted);
    end
    cycle(32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd3 || halted !== 1'b1 || bus.o_stage_data !== 32'h44332200 || cycle_count !== 8'd5) begin
      failures++;
      $display("FAIL halt_reached got=%0d/%b/%h/%0d exp=3/1/44332200/5", state, halted, bus.o_stage_data, cycle_count);
    end
    for (int i = 0; i < 5; i++) begin
      cycle($urandom, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    checks++;
    if (bus.o_stage_data !== 32'h44332200 || bus.o_stage_valid !== 4'b1110 || cycle_count !== 8'd5 || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_frozen got=%h/%b/%0d/%b exp=44332200/1110/5/1", bus.o_stage_data, bus.o_stage_valid, cycle_count, halted);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(32'h44332211, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cycle(32'h44332211, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_stage_data !== 32'h0 || bus.o_stage_valid !== 4'h0 || state !== 2'd0 ||
        cycle_count !== 8'd0 || halted !== 1'b0 || bus.o_pc_en !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%0d/%0d/%b/%b exp=0/0000/0/0/0/0",
               bus.o_stage_data, bus.o_stage_valid, state, cycle_count, halted, bus.o_pc_en);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL async_release got=%0d exp=0", state); end
    cycle(32'h0D0C0B0A, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_run();
    test_stall();
    test_flush();
    test_step();
    test_back_to_back();
    test_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
